// File: rtl/rr_arbiter_pkg.sv
// Shared types and vector helpers for the round-robin arbiter.
// Helpers work on MAX_N-wide vectors; callers pass the live width n.
package rr_arbiter_pkg;

    localparam int DEFAULT_N = 4;
    localparam int MAX_N     = 32;
    localparam int MAX_W     = 5;

    typedef logic [MAX_N-1:0] vec_t;
    typedef logic [MAX_W-1:0] idx_t;

    function automatic vec_t rotr(input vec_t vec, input int unsigned amt,
                                  input int unsigned n);
        vec_t        res;
        int unsigned src;
        res = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                src = i + amt;
                if (src >= n) src = src - n;
                res[i[MAX_W-1:0]] = vec[src[MAX_W-1:0]];
            end
        end
        return res;
    endfunction

    function automatic vec_t rotl(input vec_t vec, input int unsigned amt,
                                  input int unsigned n);
        vec_t        res;
        int unsigned dst;
        res = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                dst = i + amt;
                if (dst >= n) dst = dst - n;
                res[dst[MAX_W-1:0]] = vec[i[MAX_W-1:0]];
            end
        end
        return res;
    endfunction

    function automatic idx_t onehot_to_idx(input vec_t vec);
        idx_t res;
        res = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) res = res | i[MAX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_fixed_prio.sv
// Fixed-priority picker: isolates the lowest set bit of the input.
// Zero input yields zero output.
module rr_fixed_prio
    import rr_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter with session locking (rotate, pick, rotate back).
// Define RR_ARB_GRANT_ID_EN to add registered grant_valid / grant_id outputs.
module round_robin_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    localparam int PTR_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             session_is_finished,
`ifdef RR_ARB_GRANT_ID_EN
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_id,
`endif
    output logic [N-1:0]     grant
);

    logic [N-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0] rotate_ptr_q, rotate_ptr_d;

    logic [N-1:0]     shift_req, shift_grant, next_grant;
    logic [PTR_W-1:0] win_idx, win_idx_inc;
    vec_t             shift_req_w, next_grant_w;
    idx_t             win_idx_w;
    logic             arb_en;

    assign shift_req_w = rotr(MAX_N'(req), 32'(rotate_ptr_q), N);
    assign shift_req   = shift_req_w[N-1:0];

    rr_fixed_prio #(
        .N (N)
    ) u_fixed_prio (
        .req_i (shift_req),
        .gnt_o (shift_grant)
    );

    assign next_grant_w = rotl(MAX_N'(shift_grant), 32'(rotate_ptr_q), N);
    assign next_grant   = next_grant_w[N-1:0];

    assign win_idx_w = onehot_to_idx(MAX_N'(next_grant));
    assign win_idx   = win_idx_w[PTR_W-1:0];

    // Explicit wrap keeps non-power-of-two N correct.
    assign win_idx_inc = (win_idx == PTR_W'(N-1)) ? '0 : win_idx + PTR_W'(1);

    assign arb_en = ~|grant_q | session_is_finished | ~|(grant_q & req);

    always_comb begin
        grant_d      = grant_q;
        rotate_ptr_d = rotate_ptr_q;
        if (arb_en) begin
            grant_d = next_grant;
            if (|next_grant) rotate_ptr_d = win_idx_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= '0;
            rotate_ptr_q <= '0;
        end else begin
            grant_q      <= grant_d;
            rotate_ptr_q <= rotate_ptr_d;
        end
    end

    assign grant = grant_q;

    logic unused_bits;
    assign unused_bits = ^{shift_req_w[MAX_N-1:N], next_grant_w[MAX_N-1:N],
                           win_idx_w[MAX_W-1:PTR_W]};

`ifdef RR_ARB_GRANT_ID_EN
    logic             grant_valid_q;
    logic [PTR_W-1:0] grant_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else if (arb_en) begin
            grant_valid_q <= |next_grant;
            grant_id_q    <= win_idx;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed sequences then random traffic,
// checked against a search-based round-robin reference model.
module tb_round_robin_arbiter;

    localparam int N     = 4;
    localparam int PTR_W = $clog2(N);

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic             fin;
    logic [N-1:0]     grant;
`ifdef RR_ARB_GRANT_ID_EN
    logic             grant_valid;
    logic [PTR_W-1:0] grant_id;
`endif

    round_robin_arbiter #(
        .N (N)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (req),
        .session_is_finished (fin),
`ifdef RR_ARB_GRANT_ID_EN
        .grant_valid         (grant_valid),
        .grant_id            (grant_id),
`endif
        .grant               (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner = -1;
    int m_ptr   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Owner keeps the grant unless idle, finished, or nobody owns it;
    // otherwise search from the pointer for the first active requester.
    task automatic model_edge(input logic [N-1:0] r, input logic f,
                              input logic rs);
        int idx;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0 || f || !r[m_owner]) begin
            m_owner = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && r[idx]) m_owner = idx;
            end
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic f,
                        input logic rs, input string tag);
        logic [N-1:0] eg;
        @(negedge clk);
        req = r;
        fin = f;
        rst = rs;
        @(posedge clk);
        model_edge(r, f, rs);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check({tag, "_grant"}, 32'(grant), 32'(eg));
        check({tag, "_ptr"}, 32'(dut.rotate_ptr_q), 32'(m_ptr));
        check({tag, "_onehot"}, 32'($onehot0(grant)), 32'd1);
`ifdef RR_ARB_GRANT_ID_EN
        check({tag, "_valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        check({tag, "_id"}, 32'(grant_id),
              32'((m_owner >= 0) ? m_owner : 0));
`endif
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        fin = 1'b0;

        repeat (2) step(4'b1111, 1'b0, 1'b1, "reset");
        check("reset_const", 32'(grant), 32'h0);

        repeat (5) step(4'b0111, 1'b1, 1'b0, "rotate");
        check("rotate_last", 32'(grant), 32'h2);

        step(4'b0001, 1'b1, 1'b0, "lock_setup");
        repeat (5) step(4'b1111, 1'b0, 1'b0, "lock_hold");
        check("lock_hold_const", 32'(grant), 32'h1);
        step(4'b1111, 1'b1, 1'b0, "lock_pulse");
        check("lock_pulse_const", 32'(grant), 32'h2);
        repeat (3) step(4'b1111, 1'b0, 1'b0, "lock_after");

        step(4'b1111, 1'b1, 1'b0, "drop_setup");
        step(4'b1111, 1'b0, 1'b0, "drop_hold");
        step(4'b1011, 1'b0, 1'b0, "drop");
        check("drop_const", 32'(grant), 32'h8);
        check("wrap_ptr_const", 32'(dut.rotate_ptr_q), 32'h0);
        step(4'b1011, 1'b1, 1'b0, "wrap");
        check("wrap_const", 32'(grant), 32'h1);

        repeat (3) step(4'b0101, 1'b1, 1'b0, "sparse");
        step(4'b0000, 1'b1, 1'b0, "sparse_idle");
        step(4'b0000, 1'b0, 1'b0, "idle_hold");

        step(4'b0010, 1'b1, 1'b0, "mid_setup");
        step(4'b1111, 1'b0, 1'b1, "mid_reset");
        step(4'b1111, 1'b0, 1'b0, "post_reset");
        check("post_reset_const", 32'(grant), 32'h1);

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 49) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
